// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and the Thumb decoder.
// The master side is the fetch unit; the slave side is memory plus decoder.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid,
    input  imem_rdata, instr_ready, branch_en, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
    output imem_rdata, instr_ready, branch_en, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Thumb fetch stage: word fetch from a 1-cycle memory, split into halfwords,
// 4-deep halfword buffer with valid/ready output and branch redirect.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_REDIRECT} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        count_reg, count_next;
  logic [1:0]        rd_ptr_reg, wr_ptr_reg;
  logic              inflight_reg;
  logic              skip_lo_reg;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] req_pc_reg;

  logic              branch;
  logic              resp;
  logic              issue;
  logic              pop;
  logic [1:0]        push_n;
  logic              wr0_en, wr1_en;
  logic [1:0]        wr1_ptr;
  logic [15:0]       wr0_hw;
  logic [ADDR_W-1:0] wr0_pc, hi_pc;

  logic [15:0]       hw_q [4];
  logic [ADDR_W-1:0] pc_q [4];

  always_comb begin
    state_next = state_reg;
    branch     = bus.branch_en;
    // A response arriving in the branch cycle is wrong-path and is simply dropped.
    resp       = inflight_reg && !branch;
    pop        = (count_reg != 3'd0) && bus.instr_ready && !branch;
    issue      = !rst && !branch &&
                 ((count_reg + (inflight_reg ? 3'd2 : 3'd0)) <= 3'd2);
    push_n     = resp ? (skip_lo_reg ? 2'd1 : 2'd2) : 2'd0;
    count_next = branch ? 3'd0 : (count_reg + {1'b0, push_n} - {2'b00, pop});
    case (state_reg)
      ST_RESET:    state_next = branch ? ST_REDIRECT : ST_RUN;
      ST_RUN:      state_next = branch ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: state_next = branch ? ST_REDIRECT : ST_RUN;
      default:     state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RESET;
      count_reg    <= 3'd0;
      rd_ptr_reg   <= 2'd0;
      wr_ptr_reg   <= 2'd0;
      inflight_reg <= 1'b0;
      skip_lo_reg  <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      inflight_reg <= issue;
      if (branch) begin
        rd_ptr_reg   <= 2'd0;
        wr_ptr_reg   <= 2'd0;
        fetch_pc_reg <= {bus.branch_target[ADDR_W-1:2], 2'b00};
        skip_lo_reg  <= bus.branch_target[1];
      end else begin
        rd_ptr_reg <= rd_ptr_reg + {1'b0, pop};
        wr_ptr_reg <= wr_ptr_reg + push_n;
        if (issue) begin
          fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
          req_pc_reg   <= fetch_pc_reg;
        end
        if (resp) skip_lo_reg <= 1'b0;
      end
    end
  end

  // A word pushes up to two halfwords; after a branch to an odd halfword only the upper one.
  assign hi_pc   = req_pc_reg + ADDR_W'(2);
  assign wr0_en  = resp;
  assign wr1_en  = resp && !skip_lo_reg;
  assign wr1_ptr = wr_ptr_reg + 2'd1;
  assign wr0_hw  = skip_lo_reg ? bus.imem_rdata[31:16] : bus.imem_rdata[15:0];
  assign wr0_pc  = skip_lo_reg ? hi_pc : req_pc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [15:0]       hw_reg;
      logic [ADDR_W-1:0] pc_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          hw_reg <= 16'h0000;
          pc_reg <= RESET_PC;
        end else if (wr0_en && (wr_ptr_reg == 2'(gi))) begin
          hw_reg <= wr0_hw;
          pc_reg <= wr0_pc;
        end else if (wr1_en && (wr1_ptr == 2'(gi))) begin
          hw_reg <= bus.imem_rdata[31:16];
          pc_reg <= hi_pc;
        end
      end

      assign hw_q[gi] = hw_reg;
      assign pc_q[gi] = pc_reg;
    end
  endgenerate

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_reg;
  assign bus.instr_valid = (count_reg != 3'd0);
  assign bus.instruction = hw_q[rd_ptr_reg];
  assign bus.instr_pc    = pc_q[rd_ptr_reg];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random ready/branch/reset traffic,
// checked against a program-order model of the halfword stream.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(32)) ifc ();
  instr_fetch_if #(.ADDR_W(32)) wfc ();

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );
  instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .bus(wfc)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    case ({a[31:2], 2'b00})
      32'h0000_0000: return 32'h1C08_1840;
      32'h0000_0004: return 32'h2105_E7FE;
      32'h0000_0010: return 32'hBEEF_4770;
      32'h0000_0020: return 32'hCAFE_1234;
      default: begin
        lo = a[17:2] ^ 16'h3C5A;
        return {~lo, lo};
      end
    endcase
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction memory: data one cycle after a request.
  always @(posedge clk) begin
    if (ifc.imem_req) ifc.imem_rdata <= mem_word(ifc.imem_addr);
    if (wfc.imem_req) wfc.imem_rdata <= mem_word(wfc.imem_addr);
  end

  // Model state: next expected program-order pc, cycles since last reset/branch.
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] w_exp  = 32'hFFFF_FFF8;
  int          ev_cnt = 100;
  bit          ev_rst = 1'b0;
  int          w_idx  = 0;

  task automatic monitor();
    if (rst) begin
      chk("req_in_rst", {63'd0, ifc.imem_req}, 64'd0);
      exp_pc = 32'h0;
      w_exp  = 32'hFFFF_FFF8;
      ev_cnt = 0;
      ev_rst = 1'b1;
      w_idx  = 0;
      return;
    end
    if (ev_cnt < 100) ev_cnt++;
    if (ev_cnt == 1 || ev_cnt == 2) chk("lat_quiet", {63'd0, ifc.instr_valid}, 64'd0);
    if (ev_cnt == 3) chk("lat_valid", {63'd0, ifc.instr_valid}, 64'd1);
    if (ev_cnt == 1 && ev_rst) begin
      chk("rst_instr", {48'd0, ifc.instruction}, 64'd0);
      chk("rst_pc", {32'd0, ifc.instr_pc}, 64'd0);
      chk("rst_addr", {32'd0, ifc.imem_addr}, 64'd0);
      if (!ifc.branch_en) chk("rst_first_req", {63'd0, ifc.imem_req}, 64'd1);
    end
    if (ifc.instr_valid) begin
      chk("head_pc", {32'd0, ifc.instr_pc}, {32'd0, exp_pc});
      chk("head_instr", {48'd0, ifc.instruction}, {48'd0, hw_at(exp_pc)});
    end
    if (ifc.branch_en) begin
      chk("req_in_branch", {63'd0, ifc.imem_req}, 64'd0);
      exp_pc = {ifc.branch_target[31:1], 1'b0};
      ev_cnt = 0;
      ev_rst = 1'b0;
    end else if (ifc.instr_valid && ifc.instr_ready) begin
      $display("xfer pc=%h instr=%h", ifc.instr_pc, ifc.instruction);
      exp_pc = exp_pc + 32'd2;
    end
    // Wrap instance: always ready, never branched.
    if (wfc.imem_req && w_idx < 3) begin
      chk("wrap_addr", {32'd0, wfc.imem_addr}, {32'd0, 32'hFFFF_FFF8 + 32'(4 * w_idx)});
      w_idx++;
    end
    if (wfc.instr_valid) begin
      chk("wrap_pc", {32'd0, wfc.instr_pc}, {32'd0, w_exp});
      chk("wrap_instr", {48'd0, wfc.instruction}, {48'd0, hw_at(w_exp)});
      w_exp = w_exp + 32'd2;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_branch(input logic [31:0] tgt);
    ifc.branch_en     = 1'b1;
    ifc.branch_target = tgt;
    step(1);
    ifc.branch_en     = 1'b0;
  endtask

  initial begin
    ifc.instr_ready   = 1'b0;
    ifc.branch_en     = 1'b0;
    ifc.branch_target = 32'h0;
    wfc.instr_ready   = 1'b1;
    wfc.branch_en     = 1'b0;
    wfc.branch_target = 32'h0;

    // Straight-line fetch from reset.
    rst = 1'b1; step(2);
    rst = 1'b0; ifc.instr_ready = 1'b1; step(8);

    // Stall from reset: buffer fills, requests stop, then drain in order.
    rst = 1'b1; step(1);
    rst = 1'b0; ifc.instr_ready = 1'b0; step(8);
    chk("stall_req_off", {63'd0, ifc.imem_req}, 64'd0);
    chk("stall_full_valid", {63'd0, ifc.instr_valid}, 64'd1);
    ifc.instr_ready = 1'b1; step(8);

    // Branch to an upper halfword; bit0 of the target is ignored.
    do_branch(32'h0000_0013);
    step(6);

    // Branch while streaming, then a second branch on the next cycle.
    do_branch(32'h0000_0040);
    do_branch(32'h0000_0020);
    step(6);

    // Reset in the middle of a partly stalled stream.
    ifc.instr_ready = 1'b0; step(2);
    rst = 1'b1; step(1);
    rst = 1'b0; ifc.instr_ready = 1'b1; step(6);

    // Branch coinciding with reset is ignored.
    ifc.branch_en = 1'b1; ifc.branch_target = 32'h100; rst = 1'b1; step(1);
    ifc.branch_en = 1'b0; rst = 1'b0; step(6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ifc.instr_ready   = ($urandom_range(0, 9) < 7);
      ifc.branch_en     = ($urandom_range(0, 99) < 4);
      ifc.branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                       : ($urandom & 32'h0000_FFFF);
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    ifc.branch_en = 1'b0;
    rst = 1'b0;
    ifc.instr_ready = 1'b1;
    step(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
